alu_seq_unit: RTL

ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

---
 rtl/alu_seq_pkg.sv | 36 +++
 rtl/alu_seq_fa.sv | 21 ++
 rtl/alu_seq_unit.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
//==============================================================================
// Module      : alu_seq_pkg
// Description : Opcodes, FSM state type and flag bit indices for alu_seq_unit.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package alu_seq_pkg;

    localparam logic [2:0] c_OP_LOAD = 3'b000;
    localparam logic [2:0] c_OP_ADD  = 3'b001;
    localparam logic [2:0] c_OP_SUB  = 3'b010;
    localparam logic [2:0] c_OP_AND  = 3'b011;
    localparam logic [2:0] c_OP_OR   = 3'b100;
    localparam logic [2:0] c_OP_NOT  = 3'b101;
    localparam logic [2:0] c_OP_CLR  = 3'b110;
    localparam logic [2:0] c_OP_RSVD = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int c_FLAG_CARRY = 0;
    localparam int c_FLAG_ZERO  = 1;
    localparam int c_FLAG_NEG   = 2;
    localparam int c_FLAG_ERR   = 3;

    function automatic logic is_serial(input logic [2:0] op);
        return (op == c_OP_ADD) || (op == c_OP_SUB);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_fa.sv
//==============================================================================
// Module      : alu_seq_fa
// Description : One-bit full adder step used by the bit-serial ADD/SUB path.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_seq_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);

    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

`default_nettype wire

// File: rtl/alu_seq_unit.sv
//==============================================================================
// Module      : alu_seq_unit
// Description : Accumulator ALU with bit-serial ADD/SUB and valid/ready
//               command/result handshakes. Optional saturation: ALU_SEQ_SAT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_seq_unit
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [3:0]       res_flags,
    output logic             res_sat
);

    localparam int              c_CW   = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]  r_b;
    logic [2:0]        r_op;
    logic [c_CW-1:0]   r_cnt;
    logic              r_carry;
    logic [3:0]        r_flags;

    logic              w_serial;
    logic              w_sub;
    logic              w_last;
    logic              w_sum;
    logic              w_cout;
    logic [WIDTH-1:0]  w_shift;
    logic [WIDTH-1:0]  w_res;
    logic              w_carry;
    logic              w_err;
    logic [3:0]        w_flags;
    logic              w_cmd_ready;
    logic              w_res_valid;
`ifdef ALU_SEQ_SAT_EN
    logic              r_sat;
    logic              w_sat;
`endif

    assign w_serial = is_serial(r_op);
    assign w_sub    = (r_op == c_OP_SUB);
    assign w_last   = !w_serial || (r_cnt == c_LAST);

    // ACC and B are shifted right each serial step, so bit 0 is always the
    // current bit; the sum re-enters ACC at the MSB.
    alu_seq_fa u_fa (
        .i_a    (r_acc[0]),
        .i_b    (r_b[0] ^ w_sub),
        .i_cin  (r_carry),
        .o_s    (w_sum),
        .o_cout (w_cout)
    );

    assign w_shift = {w_sum, r_acc[WIDTH-1:1]};

    always_comb begin
        w_res   = r_acc;
        w_carry = 1'b0;
        w_err   = 1'b0;
`ifdef ALU_SEQ_SAT_EN
        w_sat   = 1'b0;
`endif
        case (r_op)
            c_OP_LOAD: w_res = r_b;
            c_OP_ADD, c_OP_SUB: begin
                w_res   = w_shift;
                w_carry = w_cout;
`ifdef ALU_SEQ_SAT_EN
                if (!w_sub && w_cout) begin
                    w_res = '1;
                    w_sat = 1'b1;
                end else if (w_sub && !w_cout) begin
                    w_res = '0;
                    w_sat = 1'b1;
                end
`endif
            end
            c_OP_AND:  w_res = r_acc & r_b;
            c_OP_OR:   w_res = r_acc | r_b;
            c_OP_NOT:  w_res = ~r_acc;
            c_OP_CLR:  w_res = '0;
            default:   w_err = 1'b1;
        endcase
    end

    always_comb begin
        w_flags               = '0;
        w_flags[c_FLAG_CARRY] = w_carry;
        w_flags[c_FLAG_ZERO]  = (w_res == '0);
        w_flags[c_FLAG_NEG]   = w_res[WIDTH-1];
        w_flags[c_FLAG_ERR]   = w_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_ready = 1'b0;
        w_res_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_res_valid = 1'b1;
                if (res_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_b     <= '0;
            r_op    <= c_OP_LOAD;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_flags <= '0;
`ifdef ALU_SEQ_SAT_EN
            r_sat   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_op    <= cmd_op;
                        r_b     <= cmd_data;
                        r_cnt   <= '0;
                        // SUB is ACC + ~B + 1: the +1 enters as the initial carry
                        r_carry <= (cmd_op == c_OP_SUB);
                    end
                end
                S_EXEC: begin
                    if (w_serial) begin
                        r_b     <= r_b >> 1;
                        r_carry <= w_cout;
                        r_cnt   <= r_cnt + c_CW'(1);
                    end
                    if (w_last) begin
                        r_acc   <= w_res;
                        r_flags <= w_flags;
`ifdef ALU_SEQ_SAT_EN
                        r_sat   <= w_sat;
`endif
                    end else begin
                        r_acc   <= w_shift;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready = w_cmd_ready;
    assign res_valid = w_res_valid;
    assign res_data  = r_acc;
    assign res_flags = r_flags;
`ifdef ALU_SEQ_SAT_EN
    assign res_sat   = r_sat;
`else
    assign res_sat   = 1'b0;
`endif

endmodule

`default_nettype wire
